// File: rtl/dac_i2s_tx.sv
// I2S transmitter for the DAC: one stereo sample pair per 256-clock frame, 64 bit slots of
// 4 clocks each. A single holding register decouples the sample source from the frame
// register that is being shifted out.
module dac_i2s_tx #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk12Mhz,
    input  logic                  RESET,
    input  logic                  DACReadyFlag,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  BCLK,
    output logic                  LRCK,
    output logic                  SDATA,
    output logic                  frame_strobe,
    output logic                  underrun
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] frame_left_q, frame_left_d;
    logic [DATA_WIDTH-1:0] frame_right_q, frame_right_d;
    logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
    logic                  hold_full_q, hold_full_d;
    logic                  first_q, first_d;
    logic                  underrun_q, underrun_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic                  sdata_q, sdata_d;
    logic                  capture;
    logic                  reload;
    logic                  run_d;
    logic [5:0]            slot_d;
    int unsigned           slot_i;
    logic [DATA_WIDTH-1:0] left_sh;
    logic [DATA_WIDTH-1:0] right_sh;

    assign sample_ready = !hold_full_q;
    assign capture      = sample_valid && !hold_full_q;
    assign frame_strobe = reload;
    assign underrun     = underrun_q;
    assign BCLK         = bclk_q;
    assign LRCK         = lrck_q;
    assign SDATA        = sdata_q;

    // Next-state: frame sequencing, reload/underrun at cnt==255, holding-register capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_left_d  = frame_left_q;
        frame_right_d = frame_right_q;
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;
        hold_full_d   = hold_full_q;
        first_d       = first_q;
        underrun_d    = underrun_q;
        reload        = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (DACReadyFlag) begin
                    // First frame after (re)entry always carries zeros.
                    state_d       = StRun;
                    frame_left_d  = '0;
                    frame_right_d = '0;
                    first_d       = 1'b1;
                end
            end
            StRun: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    if (!DACReadyFlag) begin
                        // Leave without reloading; any held pair waits for the next run.
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else begin
                        reload  = 1'b1;
                        first_d = 1'b0;
                        if (hold_full_q) begin
                            frame_left_d  = hold_left_q;
                            frame_right_d = hold_right_q;
                            hold_full_d   = 1'b0;
                        end else begin
                            frame_left_d  = '0;
                            frame_right_d = '0;
                            if (!first_q) begin
                                underrun_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Capture needs hold_full_q==0 while reload-from-hold needs it set, so they never collide.
        if (capture) begin
            hold_left_d  = sample_left;
            hold_right_d = sample_right;
            hold_full_d  = 1'b1;
        end
    end

    // Serial outputs derived from next-state so the registered pins line up with cnt_q.
    always_comb begin
        run_d    = (state_d == StRun);
        slot_d   = cnt_d[7:2];
        slot_i   = {26'd0, slot_d};
        left_sh  = frame_left_d << slot_i;
        right_sh = frame_right_d << (slot_i - 32'd32);
        bclk_d   = run_d && cnt_d[1];
        lrck_d   = run_d && (slot_d >= 6'd31) && (slot_d <= 6'd62);
        sdata_d  = 1'b0;
        if (run_d) begin
            if (slot_i < DATA_WIDTH) begin
                sdata_d = left_sh[DATA_WIDTH-1];
            end else if ((slot_i >= 32'd32) && (slot_i < 32'd32 + DATA_WIDTH)) begin
                sdata_d = right_sh[DATA_WIDTH-1];
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk12Mhz) begin
        if (RESET) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            frame_left_q  <= '0;
            frame_right_q <= '0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            hold_full_q   <= 1'b0;
            first_q       <= 1'b0;
            underrun_q    <= 1'b0;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            sdata_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_left_q  <= frame_left_d;
            frame_right_q <= frame_right_d;
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
            hold_full_q   <= hold_full_d;
            first_q       <= first_d;
            underrun_q    <= underrun_d;
            bclk_q        <= bclk_d;
            lrck_q        <= lrck_d;
            sdata_q       <= sdata_d;
        end
    end

endmodule
